// File: rtl/vend_change_ctrl.sv
// Vending controller: credit accumulation, item vend and change payout.
// Optional macro VM_STOCK_EN adds per-item stock counters and sold_out.
//
// Ports:
//   clk, rst        rising-edge clock, async active-high reset
//   coin_valid/val  coin deposit pulse and its value
//   sel_valid/sel   item selection pulse and index
//   cancel          refund request pulse
//   price_tbl       packed prices, item i at [i*W +: W]
//   chg_ready       hopper accepts the offered change coin
//   chg_valid/big   change coin offered (big = CHG_BIG, else CHG_SMALL)
//   dispense/item   one-cycle item release and its index
//   coin_rej        coin returned unaccepted (pulse)
//   insuf           credit below price (pulse)
//   sold_out        item empty (pulse, stock build only, else 0)
//   busy            controller not in WAIT
//   credit          current credit
module vend_change_ctrl #(
   parameter int W          = 8,
   parameter int N          = 4,
   parameter int CHG_BIG    = 25,
   parameter int CHG_SMALL  = 5,
   parameter int STOCK_INIT = 3,
   localparam int SW        = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            coin_valid,
   input  logic [W-1:0]    coin_val,
   input  logic            sel_valid,
   input  logic [SW-1:0]   sel,
   input  logic            cancel,
   input  logic [N*W-1:0]  price_tbl,
   input  logic            chg_ready,
   output logic            chg_valid,
   output logic            chg_big,
   output logic            dispense,
   output logic [SW-1:0]   disp_item,
   output logic            coin_rej,
   output logic            insuf,
   output logic            sold_out,
   output logic            busy,
   output logic [W-1:0]    credit
);

   typedef enum logic [2:0] {
      INIT,
      WAIT,
      CHECK,
      VEND,
      CHANGE
   } state_t;

   state_t        r_state;
   state_t        w_nxt;
   logic [W-1:0]  r_tot;
   logic [W-1:0]  w_tot_nxt;
   logic [SW-1:0] r_sel;
   logic [SW-1:0] w_sel_nxt;
   logic          r_coin_rej;
   logic          r_insuf;
   logic          w_rej;
   logic          w_insuf;
   logic          w_sold;
   logic          w_empty;
   logic          w_sel_ok;
   logic [W-1:0]  w_price;
   logic [W:0]    w_sum;

   // Extra bit catches a deposit that would wrap the credit.
   assign w_sum    = {1'b0, r_tot} + {1'b0, coin_val};
   assign w_sel_ok = ({1'b0, r_sel} < (SW+1)'(N));

   always_comb begin
      w_price = '0;
      for (int i = 0; i < N; i++)
         if (r_sel == SW'(i))
            w_price = price_tbl[i*W +: W];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= INIT;
      else
         r_state <= w_nxt;
   end

   always_comb begin
      w_nxt     = r_state;
      w_tot_nxt = r_tot;
      w_sel_nxt = r_sel;
      w_rej     = 1'b0;
      w_insuf   = 1'b0;
      w_sold    = 1'b0;
      chg_valid = 1'b0;
      chg_big   = 1'b0;
      dispense  = 1'b0;

      // Coins are only taken alone, in WAIT, and without overflow.
      if (coin_valid &&
          (r_state != WAIT || cancel || sel_valid || w_sum[W]))
         w_rej = 1'b1;

      unique case (r_state)
         INIT: begin
            w_tot_nxt = '0;
            w_nxt     = WAIT;
         end
         WAIT: begin
            if (cancel)
               w_nxt = CHANGE;
            else if (sel_valid) begin
               w_sel_nxt = sel;
               w_nxt     = CHECK;
            end else if (coin_valid && !w_sum[W])
               w_tot_nxt = w_sum[W-1:0];
         end
         CHECK: begin
            w_nxt = WAIT;
            if (!w_sel_ok)
               w_insuf = 1'b1;
            else if (w_empty)
               w_sold = 1'b1;
            else if (r_tot >= w_price) begin
               w_tot_nxt = r_tot - w_price;
               w_nxt     = VEND;
            end else
               w_insuf = 1'b1;
         end
         VEND: begin
            dispense = 1'b1;
            w_nxt    = CHANGE;
         end
         CHANGE: begin
            if (r_tot >= W'(CHG_BIG)) begin
               chg_valid = 1'b1;
               chg_big   = 1'b1;
               if (chg_ready)
                  w_tot_nxt = r_tot - W'(CHG_BIG);
            end else if (r_tot >= W'(CHG_SMALL)) begin
               chg_valid = 1'b1;
               if (chg_ready)
                  w_tot_nxt = r_tot - W'(CHG_SMALL);
            end else
               w_nxt = WAIT;
         end
         default: w_nxt = INIT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tot      <= '0;
         r_sel      <= '0;
         r_coin_rej <= 1'b0;
         r_insuf    <= 1'b0;
      end else begin
         r_tot      <= w_tot_nxt;
         r_sel      <= w_sel_nxt;
         r_coin_rej <= w_rej;
         r_insuf    <= w_insuf;
      end
   end

`ifdef VM_STOCK_EN
   logic [W-1:0] r_stock [N];
   logic         r_sold;

   always_comb begin
      w_empty = 1'b0;
      for (int i = 0; i < N; i++)
         if (r_sel == SW'(i))
            w_empty = (r_stock[i] == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++)
            r_stock[i] <= W'(STOCK_INIT);
         r_sold <= 1'b0;
      end else begin
         r_sold <= w_sold;
         for (int i = 0; i < N; i++)
            if (r_state == VEND && r_sel == SW'(i))
               r_stock[i] <= r_stock[i] - 1'b1;
      end
   end

   assign sold_out = r_sold;
`else
   logic [W:0] w_unused_stock;

   assign w_empty        = 1'b0;
   assign sold_out       = 1'b0;
   assign w_unused_stock = {w_sold, W'(STOCK_INIT)};
`endif

   assign disp_item = r_sel;
   assign coin_rej  = r_coin_rej;
   assign insuf     = r_insuf;
   assign busy      = (r_state != WAIT);
   assign credit    = r_tot;

endmodule

// File: tb/tb_vend_change_ctrl.sv
// Scoreboard bench for vend_change_ctrl: expected dispense, change
// and flag events are queued at stimulus time and popped on output.
module tb_vend_change_ctrl;

`ifdef VM_STOCK_EN
   localparam bit STK = 1'b1;
   localparam int SI  = 1;
`else
   localparam bit STK = 1'b0;
   localparam int SI  = 3;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        coin_valid = 1'b0;
   logic [7:0]  coin_val = '0;
   logic        sel_valid = 1'b0;
   logic [1:0]  sel = '0;
   logic        cancel = 1'b0;
   logic [31:0] price_tbl;
   logic        chg_ready = 1'b1;
   logic        chg_valid, chg_big, dispense;
   logic [1:0]  disp_item;
   logic        coin_rej, insuf, sold_out, busy;
   logic [7:0]  credit;

   logic [7:0]  prices [4];
   int          m_tot;
   int          m_stock [4];
   int          q_disp [$];
   int          q_chg [$];
   int          q_flag [$];
   int          n_vec = 0;
   int          n_bad = 0;

   assign price_tbl = {prices[3], prices[2], prices[1], prices[0]};

`ifdef VM_STOCK_EN
   vend_change_ctrl #(.STOCK_INIT(SI)) dut (
`else
   vend_change_ctrl dut (
`endif
      .clk(clk), .rst(rst),
      .coin_valid(coin_valid), .coin_val(coin_val),
      .sel_valid(sel_valid), .sel(sel), .cancel(cancel),
      .price_tbl(price_tbl), .chg_ready(chg_ready),
      .chg_valid(chg_valid), .chg_big(chg_big),
      .dispense(dispense), .disp_item(disp_item),
      .coin_rej(coin_rej), .insuf(insuf), .sold_out(sold_out),
      .busy(busy), .credit(credit)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Output monitor: every observed event is matched against its queue.
   always @(negedge clk) begin
      if (!rst) begin
         if (dispense) begin
            if (q_disp.size() == 0) chk("disp_unexpected", 1, 0);
            else chk("disp_item", int'(disp_item), q_disp.pop_front());
         end
         if (chg_valid && chg_ready) begin
            if (q_chg.size() == 0) chk("chg_unexpected", 1, 0);
            else chk("chg_big", int'(chg_big), q_chg.pop_front());
         end
         if (coin_rej) begin
            if (q_flag.size() == 0) chk("rej_unexpected", 1, 0);
            else chk("flag_rej", 1, q_flag.pop_front());
         end
         if (insuf) begin
            if (q_flag.size() == 0) chk("insuf_unexpected", 2, 0);
            else chk("flag_insuf", 2, q_flag.pop_front());
         end
         if (sold_out) begin
            if (q_flag.size() == 0) chk("sold_unexpected", 3, 0);
            else chk("flag_sold", 3, q_flag.pop_front());
         end
      end
   end

   task automatic push_change();
      while (m_tot >= 25) begin q_chg.push_back(1); m_tot -= 25; end
      while (m_tot >= 5) begin q_chg.push_back(0); m_tot -= 5; end
   endtask

   task automatic push_buy(input int s);
      if (STK && m_stock[s] == 0)
         q_flag.push_back(3);
      else if (m_tot >= int'(prices[s])) begin
         q_disp.push_back(s);
         m_tot -= int'(prices[s]);
         m_stock[s]--;
         push_change();
      end else
         q_flag.push_back(2);
   endtask

   task automatic coin(input int v);
      if (m_tot + v > 255) q_flag.push_back(1);
      else m_tot += v;
      @(posedge clk); #1 coin_valid = 1'b1; coin_val = 8'(v);
      @(posedge clk); #1 coin_valid = 1'b0;
   endtask

   task automatic drive_sel(input int s);
      @(posedge clk); #1 sel_valid = 1'b1; sel = 2'(s);
      @(posedge clk); #1 sel_valid = 1'b0;
   endtask

   task automatic drive_cancel();
      @(posedge clk); #1 cancel = 1'b1;
      @(posedge clk); #1 cancel = 1'b0;
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (!busy) done = 1'b1;
      end
      if (!done) chk("idle_timeout", int'(busy), 0);
   endtask

   task automatic settle(input string tag);
      repeat (2) @(posedge clk);
      #1;
      chk({tag, "_credit"}, int'(credit), m_tot);
      chk({tag, "_qleft"},
          q_disp.size() + q_chg.size() + q_flag.size(), 0);
   endtask

   task automatic rst_release();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      m_tot = 0;
      for (int i = 0; i < 4; i++) m_stock[i] = SI;
      @(negedge clk);
      chk("rst_init_busy", int'(busy), 1);
      chk("rst_credit", int'(credit), 0);
      @(negedge clk);
      chk("rst_wait_busy", int'(busy), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      prices[0] = 8'd30; prices[1] = 8'd45;
      prices[2] = 8'd60; prices[3] = 8'd75;
      #1;
      chk("rst_chg_valid", int'(chg_valid), 0);
      chk("rst_dispense", int'(dispense), 0);
      rst_release();

      // Two quarters, item 1: dispense at t+2, change at t+3.
      coin(25); coin(25);
      #1 chk("t1_credit50", int'(credit), 50);
      push_buy(1);
      drive_sel(1);
      @(negedge clk) chk("lat_t1", int'(dispense), 0);
      @(negedge clk) chk("lat_t2", int'(dispense), 1);
      @(negedge clk) chk("lat_t3", int'(chg_valid), 1);
      wait_idle();
      settle("t1");

      // Hopper stalls while 70 is owed.
      repeat (4) coin(25);
      chg_ready = 1'b0;
      push_buy(0);
      drive_sel(0);
      for (int i = 0; i < 10 && !chg_valid; i++) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_valid", int'(chg_valid), 1);
         chk("stall_big", int'(chg_big), 1);
         chk("stall_credit", int'(credit), 70);
      end
      @(posedge clk); #1 chg_ready = 1'b1;
      wait_idle();
      settle("t2");

      // Overflow rejection then full refund.
      repeat (10) coin(25);
      coin(10);
      settle("t3a");
      drive_cancel();
      push_change();
      wait_idle();
      settle("t3b");

      // Insufficient credit; coin colliding with a selection.
      coin(20);
      push_buy(2);
      drive_sel(2);
      wait_idle();
      settle("t4a");
      q_flag.push_back(1);
      push_buy(2);
      @(posedge clk); #1
         sel_valid = 1'b1; sel = 2'd2;
         coin_valid = 1'b1; coin_val = 8'd10;
      @(posedge clk); #1 sel_valid = 1'b0; coin_valid = 1'b0;
      wait_idle();
      settle("t4b");

      // Odd residue kept as credit; cancel with residue pays nothing.
      coin(57);
      push_buy(2);
      drive_sel(2);
      wait_idle();
      settle("t5a");
      drive_cancel();
      push_change();
      wait_idle();
      settle("t5b");

      // Reset in the middle of a stalled refund.
      coin(25); coin(25); coin(3);
      chg_ready = 1'b0;
      drive_cancel();
      @(negedge clk);
      chk("t6_chg_valid", int'(chg_valid), 1);
      chk("t6_credit", int'(credit), 55);
      @(posedge clk); #1 rst = 1'b1;
      #1;
      chk("t6_abort_valid", int'(chg_valid), 0);
      chk("t6_abort_credit", int'(credit), 0);
      chg_ready = 1'b1;
      rst_release();
      settle("t6");

      // Free item vends with zero credit.
      prices[0] = 8'd0;
      push_buy(0);
      drive_sel(0);
      wait_idle();
      settle("t7");
      prices[0] = 8'd30;

      // Exact price, no change.
      coin(45);
      push_buy(1);
      drive_sel(1);
      wait_idle();
      settle("t8");

      // Credit exactly at the top, then one more coin bounces.
      coin(200); coin(55); coin(1);
      settle("t9a");
      drive_cancel();
      push_change();
      wait_idle();
      settle("t9b");

      // Item 3 twice: stock build runs dry on the second.
      for (int k = 0; k < 2; k++) begin
         coin(75);
         push_buy(3);
         drive_sel(3);
         wait_idle();
         settle("t10");
      end
      drive_cancel();
      push_change();
      wait_idle();
      settle("t10c");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
